// File: rtl/slt_unit.sv
// slt_unit: two-stage pipelined set-on-compare unit with valid/ready handshakes.
//
// Stage 1 captures op and both operands. Operand B is already resolved here: the
// sign-extended immediate for SLTI/SLTIU, rt otherwise. Stage 2 captures the
// one-bit result and the illegal flag.
//
// Optional feature macro: SLT_UNIT_EQ_EN
//   defined   -> SEQ (100) and SNE (101) compare for equality / inequality
//   undefined -> 100 and 101 are reserved (rd=0, illegal=1); no equality comparator
//
// Parameters
//   WIDTH      operand/result width, 2..64
//   IMM_WIDTH  immediate width, 1..WIDTH
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   in_valid/in_ready   request handshake (op, rs, rt, imm)
//   out_valid/out_ready result handshake (rd, illegal)
//   rd                  0 or 1, zero-extended to WIDTH
//   illegal             result came from a reserved or compiled-out op

module slt_unit #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IMM_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     rs,
  input  logic [WIDTH-1:0]     rt,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     rd,
  output logic                 illegal
);

  localparam logic [2:0] OpSlt   = 3'b000;
  localparam logic [2:0] OpSltu  = 3'b001;
  localparam logic [2:0] OpSlti  = 3'b010;
  localparam logic [2:0] OpSltiu = 3'b011;
  localparam logic [2:0] OpSeq   = 3'b100;
  localparam logic [2:0] OpSne   = 3'b101;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2 state
  logic s2_valid_q, s2_valid_d;
  logic s2_res_q, s2_res_d;
  logic s2_ill_q, s2_ill_d;

  // Handshake control
  logic s2_free;
  logic s1_adv;
  logic accept;

  // Stage 2 can take new data when empty or draining this cycle.
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  // No dependence on in_valid; forced low while reset is held.
  assign in_ready = !reset && (!s1_valid_q || s2_free);
  assign accept   = in_valid && in_ready;

  // Operand B select; the size cast of a signed value sign-extends the immediate.
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] b_sel;

  assign imm_ext = WIDTH'($signed(imm));

  always_comb begin
    b_sel = rt;
    if (op == OpSlti || op == OpSltiu) begin
      b_sel = imm_ext;
    end
  end

  // Compare logic on stage 1 contents
  logic lt_signed;
  logic lt_unsigned;
  logic res_c;
  logic ill_c;

  assign lt_signed   = $signed(s1_a_q) < $signed(s1_b_q);
  assign lt_unsigned = s1_a_q < s1_b_q;

`ifdef SLT_UNIT_EQ_EN
  logic eq;
  assign eq = (s1_a_q == s1_b_q);
`endif

  always_comb begin
    res_c = 1'b0;
    ill_c = 1'b0;
    case (s1_op_q)
      OpSlt, OpSlti:   res_c = lt_signed;
      OpSltu, OpSltiu: res_c = lt_unsigned;
`ifdef SLT_UNIT_EQ_EN
      OpSeq:           res_c = eq;
      OpSne:           res_c = !eq;
`else
      OpSeq, OpSne:    ill_c = 1'b1;
`endif
      default:         ill_c = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_ill_d   = s2_ill_q;

    if (s2_free) begin
      s2_valid_d = s1_valid_q;
    end
    // Data loads only on a real transfer so an idle pipe keeps its last result.
    if (s1_adv) begin
      s2_res_d = res_c;
      s2_ill_d = ill_c;
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op;
      s1_a_d     = rs;
      s1_b_d     = b_sel;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 3'b000;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_ill_q   <= s2_ill_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign rd        = {{(WIDTH-1){1'b0}}, s2_res_q};
  assign illegal   = s2_ill_q;

endmodule

// File: doc/slt_unit.md
SLT_UNIT -- requirements
Module: slt_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal range 2..64.
REQ-002 Parameter IMM_WIDTH, default 6: immediate width in bits; legal range 1..WIDTH.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  request presented.
REQ-006 in_ready  out  1  unit can accept a request this cycle.
REQ-007 op  in  3  operation: 000 SLT, 001 SLTU, 010 SLTI, 011 SLTIU, 100 SEQ, 101 SNE, 110/111 reserved.
REQ-008 rs  in  WIDTH  first operand.
REQ-009 rt  in  WIDTH  second operand; used by register ops only.
REQ-010 imm  in  IMM_WIDTH  immediate; used by immediate ops only.
REQ-011 out_valid  out  1  result presented.
REQ-012 out_ready  in  1  consumer accepts the result this cycle.
REQ-013 rd  out  WIDTH  result: 0 or 1, zero-extended to WIDTH.
REQ-014 illegal  out  1  result belongs to a reserved or compiled-out op; travels with rd.

Function
REQ-015 A request is accepted when in_valid and in_ready are both high on a rising clk edge; a result is consumed when out_valid and out_ready are both high.
REQ-016 Pipeline: stage 1 registers the op and two WIDTH-bit operands; stage 2 registers rd and illegal.
REQ-017 Latency: an accepted request produces out_valid on the second rising edge after acceptance, provided it is not stalled.
REQ-018 Throughput: one request per cycle while out_ready stays high.
REQ-019 Operand B: for SLTI/SLTIU, imm is sign-extended to WIDTH; for every other op, operand B is rt.
REQ-020 SLT/SLTI: rd=1 if rs<B, two's-complement signed compare.
REQ-021 SLTU/SLTIU: rd=1 if rs<B, unsigned compare; for SLTIU, B is the sign-extended imm.
REQ-022 SEQ: rd=1 if rs==B. SNE: rd=1 if rs!=B.
REQ-023 Reserved op: rd=0 and illegal=1; the result still flows through the pipeline and handshake normally.
REQ-024 Stall: while out_valid is high and out_ready is low, rd, illegal and out_valid hold stable.
REQ-025 Stage 1 advances whenever stage 2 is empty or is being consumed in the same cycle.
REQ-026 in_ready = stage 1 empty OR stage 1 advancing this cycle; in_ready is combinational from out_ready, with no combinational path from in_valid.
REQ-027 Pipeline full with in_valid, out_ready both high: consume, shift and accept all occur in the same cycle, with no bubble.
REQ-028 When in_valid is low, no state changes except draining.

Reset
REQ-029 On reset assertion, both stage valid flags clear immediately; out_valid=0, rd=0, illegal=0.
REQ-030 Reset mid-operation discards all in-flight requests; no stale result appears after release.
REQ-031 in_ready=0 while reset is high; in_ready=1 on the first cycle after release.

Configuration
REQ-032 Macro SLT_UNIT_EQ_EN: when defined, SEQ and SNE behave per REQ-022.
REQ-033 When SLT_UNIT_EQ_EN is undefined, op 100 and 101 are treated as reserved per REQ-023 (rd=0, illegal=1), and no equality comparator is instantiated.

Verification
REQ-034 WIDTH=16, SLT, rs=16'h8000, rt=16'h7FFF -> rd=1, illegal=0, two cycles after acceptance.
REQ-035 SLTU, rs=16'h8000, rt=16'h7FFF -> rd=0; SLTIU, rs=16'hFFFE, imm=6'h3F -> rd=1 (B=16'hFFFF).
REQ-036 SLTI, rs=16'hFFFF, imm=6'h00 -> rd=1; rs=16'h0005, imm=6'h05 -> rd=0 (equal operands are not less).
REQ-037 Back-to-back 8 requests with out_ready held low for 3 cycles mid-stream -> all 8 results in order, none dropped or duplicated, in_ready low only while both stages are full.
REQ-038 op=3'b110, and op=3'b100 without SLT_UNIT_EQ_EN -> rd=0, illegal=1; with the macro, SEQ rs=rt=16'h1234 -> rd=1, illegal=0.
REQ-039 Assert reset with both stages full and out_ready low -> out_valid drops immediately; after release, the first result out corresponds to the first post-reset request.
